// File: rtl/move_scheduler_pkg.sv
// Shared definitions for the move scheduler.
//   STEP_THRESHOLD  : value subtracted from the DDA accumulator on every step
//   BUFFER_BITS_DEF : default log2 depth of the segment buffer
//   state_t         : scheduler FSM encodings
package move_scheduler_pkg;

  localparam logic [63:0] STEP_THRESHOLD  = 64'h7fffffffffffff9b;
  localparam int          BUFFER_BITS_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/move_scheduler_if.sv
// Segment write channel from the SPI command decoder.
//   wr_valid     : segment write request
//   wr_ready     : buffer has room
//   wr_dir       : segment direction
//   wr_duration  : segment length in ticks (unsigned)
//   wr_increment : initial per-tick accumulator increment (signed)
//   wr_incinc    : per-tick increment delta (signed)
interface move_scheduler_if #(
  parameter int DW = 64
);
  logic          wr_valid;
  logic          wr_ready;
  logic          wr_dir;
  logic [DW-1:0] wr_duration;
  logic [DW-1:0] wr_increment;
  logic [DW-1:0] wr_incinc;

  modport master (output wr_valid, wr_dir, wr_duration, wr_increment, wr_incinc,
                  input  wr_ready);
  modport slave  (input  wr_valid, wr_dir, wr_duration, wr_increment, wr_incinc,
                  output wr_ready);
endinterface

// File: rtl/move_scheduler_seg_fifo.sv
// Ring buffer holding queued move segments.
//   CLK, resetn : clock, async active-low reset
//   push, pop   : enqueue din / dequeue head
//   flush       : drop all entries (wins over push/pop)
//   din, dout   : entry in / head entry out
//   level       : occupied entries
//   full        : level == depth
module move_scheduler_seg_fifo #(
  parameter int BUFFER_BITS = 1,
  parameter int WIDTH       = 8
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic [BUFFER_BITS:0] level,
  output logic                 full
);
  localparam int DEPTH = 2 ** BUFFER_BITS;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [BUFFER_BITS-1:0] wr_ptr;
  logic [BUFFER_BITS-1:0] rd_ptr;

  // storage is not reset; contents are meaningless until written
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + BUFFER_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + BUFFER_BITS'(1);
      case ({push, pop})
        2'b10:   level <= level + (BUFFER_BITS+1)'(1);
        2'b01:   level <= level - (BUFFER_BITS+1)'(1);
        default: ;
      endcase
    end
  end

  assign dout = mem[rd_ptr];
  assign full = (level == (BUFFER_BITS+1)'(DEPTH));

endmodule

// File: rtl/move_scheduler.sv
// Buffered move sequencer for the single-axis DDA step generator.
// Queues segments in a ring buffer and executes them back-to-back at a
// programmable tick rate, producing step/dir for the H-bridge driver.
//   CLK, resetn    : clock, async active-low reset
//   wr             : segment write channel (slave modport)
//   clock_divisor  : CLK cycles per tick, 0 behaves as 1
//   abort          : synchronous flush and stop
//   step, dir      : step pulse and current direction
//   busy           : a segment is executing
//   segment_done   : one-cycle pulse when a segment retires
//   level          : occupied buffer entries
// Build option: STEP_PULSE_STRETCH_EN holds step high from a stepping tick
// until the next tick (or segment end) instead of a one-cycle pulse.
//
// state | meaning
// IDLE  | buffer empty, nothing executing
// LOAD  | pop head segment, latch its parameters
// RUN   | divide clock into ticks, advance DDA each tick
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int BUFFER_BITS = BUFFER_BITS_DEF,
  parameter int DW          = 64,
  parameter int DIV_W       = 8
) (
  input  logic                 CLK,
  input  logic                 resetn,
  move_scheduler_if.slave      wr,
  input  logic [DIV_W-1:0]     clock_divisor,
  input  logic                 abort,
  output logic                 step,
  output logic                 dir,
  output logic                 busy,
  output logic                 segment_done,
  output logic [BUFFER_BITS:0] level
);
  localparam int EW = 1 + 3 * DW;

  state_t         state, state_next;
  logic           push, pop, full;
  logic [EW-1:0]  fifo_dout;
  logic           head_dir;
  logic [DW-1:0]  head_dur, head_inc, head_incinc;

  logic [DW-1:0]    acc, inc_r, seg_inc, seg_incinc, tickdown;
  logic [DW-1:0]    inc_next, sum;
  logic [DIV_W-1:0] divcnt, div_lat, div_eff;
  logic             first, tick, last, pos;
`ifdef STEP_PULSE_STRETCH_EN
  logic             step_hold;
`endif

  // abort drops a same-cycle write
  assign push        = wr.wr_valid & wr.wr_ready & ~abort;
  assign wr.wr_ready = ~full;

  move_scheduler_seg_fifo #(
    .BUFFER_BITS (BUFFER_BITS),
    .WIDTH       (EW)
  ) u_seg_fifo (
    .CLK    (CLK),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .flush  (abort),
    .din    ({wr.wr_dir, wr.wr_duration, wr.wr_increment, wr.wr_incinc}),
    .dout   (fifo_dout),
    .level  (level),
    .full   (full)
  );

  assign {head_dir, head_dur, head_inc, head_incinc} = fifo_dout;

  // divisor is re-sampled at LOAD and at every tick, so a change lands
  // on the following tick period
  assign div_eff  = (clock_divisor == '0) ? DIV_W'(1) : clock_divisor;
  assign tick     = (state == ST_RUN) && (divcnt == div_lat - DIV_W'(1));
  assign last     = (tickdown == DW'(1));
  assign inc_next = first ? seg_inc : inc_r + seg_incinc;
  assign sum      = acc + inc_next;
  assign pos      = ~sum[DW-1] & (|sum);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (level != '0) state_next = ST_LOAD;
      ST_LOAD: state_next = (head_dur == '0) ? ST_IDLE : ST_RUN;
      ST_RUN:  if (tick && last) state_next = (level != '0) ? ST_LOAD : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_comb begin
    pop          = (state == ST_LOAD);
    segment_done = ((state == ST_LOAD) && (head_dur == '0)) || (tick && last);
`ifdef STEP_PULSE_STRETCH_EN
    step         = (state == ST_RUN) && (tick ? pos : step_hold);
`else
    step         = tick && pos;
`endif
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      acc        <= '0;
      inc_r      <= '0;
      seg_inc    <= '0;
      seg_incinc <= '0;
      tickdown   <= '0;
      divcnt     <= '0;
      div_lat    <= DIV_W'(1);
      first      <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
`ifdef STEP_PULSE_STRETCH_EN
      step_hold  <= 1'b0;
`endif
    end else if (abort) begin
      acc        <= '0;
      divcnt     <= '0;
      first      <= 1'b0;
      busy       <= 1'b0;
`ifdef STEP_PULSE_STRETCH_EN
      step_hold  <= 1'b0;
`endif
    end else begin
`ifdef STEP_PULSE_STRETCH_EN
      if (state != ST_RUN) step_hold <= 1'b0;
      else if (tick)       step_hold <= pos;
`endif
      case (state)
        ST_LOAD: begin
          tickdown   <= head_dur;
          dir        <= head_dir;
          seg_inc    <= head_inc;
          seg_incinc <= head_incinc;
          first      <= 1'b1;
          divcnt     <= '0;
          div_lat    <= div_eff;
          busy       <= (head_dur != '0);
        end
        ST_RUN: begin
          if (tick) begin
            divcnt   <= '0;
            div_lat  <= div_eff;
            first    <= 1'b0;
            inc_r    <= inc_next;
            acc      <= pos ? sum - DW'(STEP_THRESHOLD) : sum;
            tickdown <= tickdown - DW'(1);
            // busy stays up across a chained LOAD
            if (last) busy <= (level != '0);
          end else begin
            divcnt   <= divcnt + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
module tb_move_scheduler;
  localparam logic [63:0] THR = 64'h7fffffffffffff9b;

  logic       CLK = 1'b0;
  logic       resetn;
  logic [7:0] clock_divisor;
  logic       abort;
  logic       step, dir, busy, segment_done;
  logic [1:0] level;

  move_scheduler_if #(.DW(64)) wif();

  move_scheduler dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .wr            (wif),
    .clock_divisor (clock_divisor),
    .abort         (abort),
    .step          (step),
    .dir           (dir),
    .busy          (busy),
    .segment_done  (segment_done),
    .level         (level)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int busy_cnt = 0;
  int step_q[$];
  int done_q[$];
  int step_base, done_base, busy_base;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (step)         step_q.push_back(cyc);
    if (segment_done) done_q.push_back(cyc);
    if (busy)         busy_cnt++;
  end

  typedef struct {
    logic        d;
    logic [63:0] dur;
    logic [63:0] inc;
    logic [63:0] incinc;
    logic [7:0]  div;
    logic [15:0] tick_mask;
    logic [63:0] acc_end;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic mark_mon();
    step_base = step_q.size();
    done_base = done_q.size();
    busy_base = busy_cnt;
  endtask

  function automatic logic [63:0] step_mask(input int base);
    logic [63:0] m = '0;
    for (int i = step_base; i < step_q.size(); i++) begin
      int rel = step_q[i] - base;
      if (rel >= 0 && rel < 63) m[rel] = 1'b1;
      else m[63] = 1'b1;
    end
    return m;
  endfunction

  function automatic int n_done();
    return done_q.size() - done_base;
  endfunction

  function automatic int done_rel(input int k, input int base);
    return (n_done() > k) ? done_q[done_base + k] - base : -1;
  endfunction

  task automatic push_seg(input logic d, input logic [63:0] dur, input logic [63:0] inc,
                          input logic [63:0] incinc, output int acpt);
    acpt = -1;
    @(negedge CLK);
    wif.wr_valid     = 1'b1;
    wif.wr_dir       = d;
    wif.wr_duration  = dur;
    wif.wr_increment = inc;
    wif.wr_incinc    = incinc;
    for (int n = 0; n < 50; n++) begin
      if (wif.wr_ready) begin
        acpt = cyc + 1;
        @(posedge CLK);
        break;
      end
      @(posedge CLK);
      @(negedge CLK);
    end
    #1 wif.wr_valid = 1'b0;
    check("push_accepted", 64'(acpt >= 0), 64'd1);
  endtask

  task automatic do_abort();
    @(negedge CLK);
    abort = 1'b1;
    @(posedge CLK);
    #1 abort = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    for (int n = 0; n < 200 && cyc < target; n++) @(negedge CLK);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, d, tmp;
    logic [63:0] exp_m;

    vecs[0] = '{1'b1, 64'd4,  THR,                   64'd0,                 8'd3, 16'h000F, 64'd0};
    vecs[1] = '{1'b0, 64'd10, 64'd0,                 64'd0,                 8'd1, 16'h0000, 64'd0};
    vecs[2] = '{1'b1, 64'd3,  64'h4000000000000000,  64'd0,                 8'd2, 16'h0003, 64'hC0000000000000CA};
    vecs[3] = '{1'b0, 64'd3,  64'd0,                 64'h4000000000000000,  8'd0, 16'h0006, 64'hC0000000000000CA};
    vecs[4] = '{1'b1, 64'd2,  64'hFFFFFFFFFFFFFFFB,  64'd0,                 8'd1, 16'h0000, 64'hFFFFFFFFFFFFFFF6};

    resetn = 1'b0;
    abort = 1'b0;
    clock_divisor = 8'd1;
    wif.wr_valid = 1'b0;
    wif.wr_dir = 1'b0;
    wif.wr_duration = '0;
    wif.wr_increment = '0;
    wif.wr_incinc = '0;

    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    check("rst_step", 64'(step), 64'd0);
    check("rst_dir", 64'(dir), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(segment_done), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ready", 64'(wif.wr_ready), 64'd1);
    check("rst_acc", dut.acc, 64'd0);
    check("rst_state", 64'(dut.state), 64'd0);

    for (int i = 0; i < 5; i++) begin
      d = (vecs[i].div == 8'd0) ? 1 : int'(vecs[i].div);
      clock_divisor = vecs[i].div;
      do_abort();
      mark_mon();
      push_seg(vecs[i].d, vecs[i].dur, vecs[i].inc, vecs[i].incinc, a0);
      repeat (int'(vecs[i].dur) * d + 8) @(negedge CLK);
      exp_m = '0;
      for (int j = 1; j <= int'(vecs[i].dur); j++) begin
        if (vecs[i].tick_mask[j-1]) begin
`ifdef STEP_PULSE_STRETCH_EN
          if (j < int'(vecs[i].dur))
            for (int k = 0; k < d; k++) exp_m[1 + j*d + k] = 1'b1;
          else
            exp_m[1 + j*d] = 1'b1;
`else
          exp_m[1 + j*d] = 1'b1;
`endif
        end
      end
      check($sformatf("v%0d_step_cycles", i), step_mask(a0), exp_m);
      check($sformatf("v%0d_done_count", i), 64'(n_done()), 64'd1);
      check($sformatf("v%0d_done_cycle", i), 64'(done_rel(0, a0)), 64'(1 + int'(vecs[i].dur) * d));
      check($sformatf("v%0d_busy_cycles", i), 64'(busy_cnt - busy_base), 64'(int'(vecs[i].dur) * d));
      check($sformatf("v%0d_dir", i), 64'(dir), 64'(vecs[i].d));
      check($sformatf("v%0d_acc", i), dut.acc, vecs[i].acc_end);
    end

    // back-to-back segments against a depth-2 buffer
    clock_divisor = 8'd1;
    do_abort();
    mark_mon();
    push_seg(1'b0, 64'd5, 64'd0, 64'd0, a0);
    push_seg(1'b1, 64'd5, 64'd0, 64'd0, a1);
    push_seg(1'b0, 64'd5, 64'd0, 64'd0, a2);
    check("bp_second_accept", 64'(a1 - a0), 64'd1);
    check("bp_third_accept", 64'(a2 - a0), 64'd3);
    wait_cyc(a0 + 25);
    check("bp_done_count", 64'(n_done()), 64'd3);
    check("bp_done0", 64'(done_rel(0, a0)), 64'd6);
    check("bp_done1", 64'(done_rel(1, a0)), 64'd12);
    check("bp_done2", 64'(done_rel(2, a0)), 64'd18);
    check("bp_busy_cycles", 64'(busy_cnt - busy_base), 64'd17);
    check("bp_no_steps", 64'(step_q.size() - step_base), 64'd0);

    // zero-length segment between two short ones
    do_abort();
    mark_mon();
    push_seg(1'b1, 64'd2, THR, 64'd0, a0);
    push_seg(1'b1, 64'd0, THR, 64'd0, a1);
    push_seg(1'b1, 64'd2, THR, 64'd0, a2);
    wait_cyc(a0 + 14);
    check("z_done_count", 64'(n_done()), 64'd3);
    check("z_done0", 64'(done_rel(0, a0)), 64'd3);
    check("z_done1", 64'(done_rel(1, a0)), 64'd4);
    check("z_done2", 64'(done_rel(2, a0)), 64'd8);
    exp_m = '0;
    exp_m[2] = 1'b1; exp_m[3] = 1'b1; exp_m[7] = 1'b1; exp_m[8] = 1'b1;
    check("z_step_cycles", step_mask(a0), exp_m);
    check("z_busy_after", 64'(busy), 64'd0);

    // abort mid-RUN with one entry queued and a colliding write
    do_abort();
    push_seg(1'b1, 64'd10, 64'hFFFFFFFFFFFFFFFD, 64'd0, a0);
    push_seg(1'b0, 64'd5, 64'd0, 64'd0, a1);
    wait_cyc(a0 + 4);
    check("ab_pre_level", 64'(level), 64'd1);
    check("ab_pre_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    wif.wr_valid = 1'b1;
    wif.wr_duration = 64'd7;
    @(posedge CLK);
    #1;
    abort = 1'b0;
    wif.wr_valid = 1'b0;
    @(negedge CLK);
    mark_mon();
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_level", 64'(level), 64'd0);
    check("ab_step", 64'(step), 64'd0);
    check("ab_ready", 64'(wif.wr_ready), 64'd1);
    check("ab_done", 64'(segment_done), 64'd0);
    check("ab_acc", dut.acc, 64'd0);
    repeat (10) @(negedge CLK);
    check("ab_level_later", 64'(level), 64'd0);
    check("ab_no_done_later", 64'(n_done()), 64'd0);
    check("ab_no_busy_later", 64'(busy_cnt - busy_base), 64'd0);

    // asynchronous reset in the middle of a stepping segment
    do_abort();
    push_seg(1'b1, 64'd10, THR, 64'd0, a0);
    wait_cyc(a0 + 4);
    check("rs_pre_step", 64'(step), 64'd1);
    check("rs_pre_dir", 64'(dir), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("rs_step", 64'(step), 64'd0);
    check("rs_dir", 64'(dir), 64'd0);
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_level", 64'(level), 64'd0);
    check("rs_ready", 64'(wif.wr_ready), 64'd1);
    check("rs_done", 64'(segment_done), 64'd0);
    check("rs_state", 64'(dut.state), 64'd0);
    @(negedge CLK);
    resetn = 1'b1;
    tmp = cyc;
    wait_cyc(tmp + 3);
    check("rs_idle_after", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
